// File: rtl/shift_pkg.sv
// Shared types for the shift command queue.
//   shift_op_e    : command opcode (SLL/SRL/SRA/reserved)
//   shift_entry_t : one decoded FIFO entry {data, sa, right, arith, err}
//   decode_op     : opcode -> barrel shifter controls plus error flag
package shift_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SA_W   = 5;
   localparam int unsigned OP_W   = 2;

   typedef enum logic [OP_W-1:0] {
      SLL  = 2'b00,
      SRL  = 2'b01,
      SRA  = 2'b10,
      RSVD = 2'b11
   } shift_op_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SA_W-1:0]   sa;
      logic              right;
      logic              arith;
      logic              err;
   } shift_entry_t;

   typedef struct packed {
      logic right;
      logic arith;
      logic err;
   } shift_ctl_t;

   // Reserved opcode decodes as a left shift flagged with err; its result is forced to zero later.
   function automatic shift_ctl_t decode_op(input shift_op_e op);
      shift_ctl_t ctl;
      ctl = '0;
      case (op)
         SLL:     ctl = '{right: 1'b0, arith: 1'b0, err: 1'b0};
         SRL:     ctl = '{right: 1'b1, arith: 1'b0, err: 1'b0};
         SRA:     ctl = '{right: 1'b1, arith: 1'b1, err: 1'b0};
         default: ctl = '{right: 1'b0, arith: 1'b0, err: 1'b1};
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// DEPTH-entry FIFO of decoded shift commands.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata at tail (ignored when full)
//   wdata    : entry to write
//   pop      : drop head entry (ignored when empty)
//   head     : storage contents at the read pointer
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
module shift_cmd_fifo
   import shift_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  shift_entry_t             wdata,
   input  logic                     pop,
   output shift_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   shift_entry_t      mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Head is a plain read of storage; when empty it shows whatever that slot last held.
   assign head = mem[rd_ptr];

   // Storage entries, each written only when the tail points at it.
   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mem[g] <= '0;
         end else if (push_ok && (wr_ptr == PTR_W'(g))) begin
            mem[g] <= wdata;
         end
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/shift_cmd_queue.sv
// Issue stage in front of an external 32-bit barrel shifter.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : command handshake; in_ready = (count < DEPTH)
//   in_data/in_sa/in_op   : operand, shift amount, opcode (00 SLL, 01 SRL, 10 SRA, 11 reserved)
//   sh_d/sh_sa/sh_right/sh_airthmetic : head entry controls to the shifter
//   sh_out                : combinational shifter result
//   res_valid/res_ready   : result slot handshake
//   res_data/res_err      : captured result (zero on reserved op) and error flag
//   count                 : FIFO occupancy
module shift_cmd_queue
   import shift_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SA_W-1:0]         in_sa,
   input  logic [OP_W-1:0]         in_op,
   output logic [DATA_W-1:0]       sh_d,
   output logic [SA_W-1:0]         sh_sa,
   output logic                    sh_right,
   output logic                    sh_airthmetic,
   input  logic [DATA_W-1:0]       sh_out,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [DATA_W-1:0]       res_data,
   output logic                    res_err,
   output logic [$clog2(DEPTH):0]  count
);

   shift_ctl_t    ctl;
   shift_entry_t  push_entry;
   shift_entry_t  head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          load;

   // Decode at push so the head drives the shifter straight from storage.
   assign ctl        = decode_op(shift_op_e'(in_op));
   assign push_entry = '{data:  in_data,
                         sa:    in_sa,
                         right: ctl.right,
                         arith: ctl.arith,
                         err:   ctl.err};

   // No bypass: a full queue refuses even if the head pops this cycle.
   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign load     = !fifo_empty && (!res_valid || res_ready);

   shift_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_entry),
      .pop   (load),
      .head  (head),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign sh_d          = head.data;
   assign sh_sa         = head.sa;
   assign sh_right      = head.right;
   assign sh_airthmetic = head.arith;

   // Result slot: capture shifter output when the head moves in, else drain on ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
      end else if (load) begin
         res_valid <= 1'b1;
         res_data  <= head.err ? '0 : sh_out;
         res_err   <= head.err;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Self-checking bench for shift_cmd_queue with a behavioural barrel shifter alongside.
module tb_shift_cmd_queue;
   import shift_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_sa;
   logic [1:0]  in_op;
   logic [31:0] sh_d;
   logic [4:0]  sh_sa;
   logic        sh_right;
   logic        sh_airthmetic;
   logic [31:0] sh_out;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_err;
   logic [2:0]  count;

   shift_cmd_queue #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_sa         (in_sa),
      .in_op         (in_op),
      .sh_d          (sh_d),
      .sh_sa         (sh_sa),
      .sh_right      (sh_right),
      .sh_airthmetic (sh_airthmetic),
      .sh_out        (sh_out),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .res_err       (res_err),
      .count         (count)
   );

   // Barrel shifter neighbour.
   always_comb begin
      if (!sh_right)          sh_out = sh_d << sh_sa;
      else if (sh_airthmetic) sh_out = 32'($signed(sh_d) >>> sh_sa);
      else                    sh_out = sh_d >> sh_sa;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t mq[$];
   logic m_rv;
   exp_t m_slot;
   int   errors = 0;
   int   checks = 0;

   // Expected result of one command, straight from the opcode definitions.
   function automatic exp_t ref_result(input logic [31:0] d, input logic [4:0] sa,
                                       input logic [1:0] op);
      exp_t r;
      r.data = '0;
      r.err  = 1'b0;
      case (op)
         2'b00:   r.data = d << sa;
         2'b01:   r.data = d >> sa;
         2'b10:   r.data = (d >> sa) | (d[31] ? ~(32'hFFFF_FFFF >> sa) : 32'h0);
         default: r.err  = 1'b1;
      endcase
      return r;
   endfunction

   // One clock: update the reference from the inputs held across the edge, return at negedge.
   task automatic advance();
      bit   acc, ld, cons;
      exp_t nxt;
      acc  = in_valid && (mq.size() < int'(DEPTH));
      ld   = (mq.size() > 0) && (!m_rv || res_ready);
      cons = m_rv && res_ready;
      nxt  = ref_result(in_data, in_sa, in_op);
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_rv   = 1'b0;
         m_slot = '0;
      end else begin
         if (ld) begin
            m_slot = mq.pop_front();
            m_rv   = 1'b1;
         end else if (cons) begin
            m_rv = 1'b0;
         end
         if (acc) mq.push_back(nxt);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] sa,
                        input logic [1:0] op);
      in_valid = v;
      in_data  = d;
      in_sa    = sa;
      in_op    = op;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) advance();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 5'd0, 2'b00);
      res_ready = 1'b0;
      mq.delete();
      m_rv   = 1'b0;
      m_slot = '0;
      #3;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
      checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if ({sh_d, sh_sa, sh_right, sh_airthmetic} !== 39'h0)
         begin errors++; $display("FAIL reset_sh got d=%h sa=%0d r=%b a=%b exp all 0", sh_d, sh_sa, sh_right, sh_airthmetic); end
      @(negedge clk);
   endtask

   task automatic test_directed();
      res_ready = 1'b1;
      drive(1'b1, 32'd45356, 5'd5, 2'b00);
      advance();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL dir_latency1 res_valid got=%b exp=0", res_valid); end
      checks++; if (sh_d !== 32'd45356 || sh_sa !== 5'd5) begin errors++; $display("FAIL dir_sh_head got d=%0d sa=%0d exp 45356/5", sh_d, sh_sa); end
      drive(1'b1, 32'd453556, 5'd8, 2'b01);
      advance();
      checks++; if (res_valid !== 1'b1 || res_data !== 32'd1451392)
         begin errors++; $display("FAIL dir_sll got v=%b d=%0d exp v=1 d=1451392", res_valid, res_data); end
      drive(1'b1, 32'h8000_0010, 5'd4, 2'b10);
      advance();
      checks++; if (res_valid !== 1'b1 || res_data !== 32'd1771)
         begin errors++; $display("FAIL dir_srl got v=%b d=%0d exp v=1 d=1771", res_valid, res_data); end
      in_valid = 1'b0;
      advance();
      checks++; if (res_valid !== 1'b1 || res_data !== 32'hF800_0001 || res_err !== 1'b0)
         begin errors++; $display("FAIL dir_sra got v=%b d=%h e=%b exp v=1 d=f8000001 e=0", res_valid, res_data, res_err); end
      advance();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL dir_empty res_valid got=%b exp=0", res_valid); end
   endtask

   task automatic test_backpressure();
      int acc;
      acc = 0;
      res_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, $urandom, 5'($urandom), 2'($urandom_range(0, 2)));
         #1;
         if (in_valid && in_ready) acc++;
         advance();
      end
      in_valid = 1'b0;
      checks++; if (acc != 5) begin errors++; $display("FAIL bp_accepted got=%0d exp=5", acc); end
      checks++; if (in_ready !== 1'b0 || count !== 3'd4)
         begin errors++; $display("FAIL bp_full got in_ready=%b count=%0d exp 0/4", in_ready, count); end
      res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (res_valid !== (i < 5) || (i < 5 && res_data !== m_slot.data)) begin
            errors++;
            $display("FAIL bp_drain%0d got v=%b d=%h exp v=%b d=%h", i, res_valid, res_data, (i < 5), m_slot.data);
         end
         advance();
      end
   endtask

   task automatic test_reserved();
      res_ready = 1'b1;
      drive(1'b1, 32'hFFFF_FFFF, 5'd3, 2'b11);
      advance();
      drive(1'b1, 32'h0000_0001, 5'd4, 2'b00);
      advance();
      in_valid = 1'b0;
      checks++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 32'h0)
         begin errors++; $display("FAIL rsvd got v=%b e=%b d=%h exp v=1 e=1 d=0", res_valid, res_err, res_data); end
      advance();
      checks++; if (res_valid !== 1'b1 || res_err !== 1'b0 || res_data !== 32'h10)
         begin errors++; $display("FAIL rsvd_next got v=%b e=%b d=%h exp v=1 e=0 d=10", res_valid, res_err, res_data); end
      drain();
   endtask

   task automatic test_steady();
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom, 5'($urandom), 2'($urandom));
         advance();
      end
      checks++; if (count !== 3'd2 || res_valid !== 1'b1)
         begin errors++; $display("FAIL steady_setup got count=%0d v=%b exp 2/1", count, res_valid); end
      res_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, $urandom, 5'($urandom), 2'($urandom));
         #1;
         checks++;
         if (count !== 3'd2 || in_ready !== 1'b1 || res_valid !== 1'b1 ||
             res_data !== m_slot.data || res_err !== m_slot.err) begin
            errors++;
            $display("FAIL steady%0d got cnt=%0d rdy=%b v=%b d=%h e=%b exp cnt=2 rdy=1 v=1 d=%h e=%b",
                     i, count, in_ready, res_valid, res_data, res_err, m_slot.data, m_slot.err);
         end
         advance();
      end
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 9) < 7), $urandom, 5'($urandom), 2'($urandom));
         res_ready = ($urandom_range(0, 9) < 6);
         #1;
         checks++;
         if (res_valid !== m_rv || (m_rv && (res_data !== m_slot.data || res_err !== m_slot.err)) ||
             count !== 3'(mq.size()) || in_ready !== (mq.size() < int'(DEPTH))) begin
            errors++;
            $display("FAIL rand%0d got v=%b d=%h e=%b cnt=%0d rdy=%b exp v=%b d=%h e=%b cnt=%0d",
                     i, res_valid, res_data, res_err, count, in_ready, m_rv, m_slot.data, m_slot.err, mq.size());
         end
         advance();
      end
      drain();
   endtask

   task automatic test_midreset();
      exp_t want;
      int   seen;
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, $urandom, 5'($urandom), 2'($urandom_range(0, 2)));
         advance();
      end
      in_valid = 1'b0;
      checks++; if (count !== 3'd3 || res_valid !== 1'b1)
         begin errors++; $display("FAIL mrst_setup got count=%0d v=%b exp 3/1", count, res_valid); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (res_valid !== 1'b0 || res_data !== 32'h0 || res_err !== 1'b0 || count !== 3'd0 ||
          {sh_d, sh_sa, sh_right, sh_airthmetic} !== 39'h0) begin
         errors++;
         $display("FAIL mrst_async got v=%b d=%h e=%b cnt=%0d shd=%h exp all 0", res_valid, res_data, res_err, count, sh_d);
      end
      mq.delete();
      m_rv   = 1'b0;
      m_slot = '0;
      @(negedge clk);
      rst = 1'b0;
      res_ready = 1'b1;
      drive(1'b1, 32'hC000_1234, 5'd7, 2'b10);
      want = ref_result(32'hC000_1234, 5'd7, 2'b10);
      advance();
      in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (res_valid === 1'b1) begin
            seen++;
            checks++; if (res_data !== want.data || res_err !== 1'b0)
               begin errors++; $display("FAIL mrst_result got d=%h e=%b exp d=%h e=0", res_data, res_err, want.data); end
         end
         advance();
      end
      checks++; if (seen != 1) begin errors++; $display("FAIL mrst_count got=%0d results exp=1", seen); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reserved();
      test_steady();
      test_random();
      test_midreset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
